// File: rtl/wb_register_file_pkg.sv
// -----------------------------------------------------------------------------
// wb_register_file_pkg
//
// Shared constants for the writeback stage / register file slice.
//   DEFAULT_WB_IO_BUS_SIZE : datapath width of the writeback buses
//   DEFAULT_REG_ADDR_SIZE  : register address width (2**N registers)
//   DEFAULT_WR_COUNT_SIZE  : width of the committed-write counter
//   REG_ZERO               : hard-wired zero register address
//   LOW / HIGH / CLEAR     : single-bit constants used by the control logic
//
// Helper:
//   is_reg_zero(addr, width) : true when the low 'width' bits of addr are zero
// -----------------------------------------------------------------------------
package wb_register_file_pkg;

   localparam int DEFAULT_WB_IO_BUS_SIZE = 32;
   localparam int DEFAULT_REG_ADDR_SIZE  = 5;
   localparam int DEFAULT_WR_COUNT_SIZE  = 32;

   localparam int REG_ZERO = 0;

   localparam logic LOW   = 1'b0;
   localparam logic HIGH  = 1'b1;
   localparam logic CLEAR = 1'b0;

   // Address comparison against the zero register that works for any
   // address width up to 32 bits.
   function automatic logic is_reg_zero(input logic [31:0] addr,
                                        input int          width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return ((addr & mask) == 32'(REG_ZERO));
   endfunction

endpackage

// File: rtl/wb_register_file_wb_mux.sv
// -----------------------------------------------------------------------------
// wb_register_file_wb_mux
//
// 2:1 writeback value selector. Purely combinational; the selected value is
// both the data committed to the register file and the forwarding source.
//
// Ports:
//   i_mem_to_reg  in  1         1 = load data, 0 = ALU result
//   i_mem_result  in  BUS_SIZE  load data from MEM/WB
//   i_alu_result  in  BUS_SIZE  ALU result from MEM/WB
//   o_wb_data     out BUS_SIZE  selected writeback value
// -----------------------------------------------------------------------------
module wb_register_file_wb_mux
   import wb_register_file_pkg::*;
#(
   parameter int BUS_SIZE = DEFAULT_WB_IO_BUS_SIZE
) (
   input  logic                i_mem_to_reg,
   input  logic [BUS_SIZE-1:0] i_mem_result,
   input  logic [BUS_SIZE-1:0] i_alu_result,
   output logic [BUS_SIZE-1:0] o_wb_data
);

   always_comb begin
      o_wb_data = i_alu_result;
      if (i_mem_to_reg == HIGH) begin
         o_wb_data = i_mem_result;
      end
   end

endmodule

// File: rtl/wb_register_file.sv
// -----------------------------------------------------------------------------
// wb_register_file
//
// Writeback stage plus architectural register file. Chooses the writeback
// value (load data or ALU result), commits it to the general-purpose register
// array, serves two ID-stage read ports and one debug read port, and tracks
// halt retirement and the number of committed register writes.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - when defined, read ports A/B return the value being
//                       committed this cycle if they address the destination
//                       register (write-through). The debug port never
//                       bypasses. When undefined, ports return the array
//                       contents as they were before the edge.
//
// Ports:
//   i_clk         in  1              rising-edge clock
//   i_reset       in  1              synchronous, active-high reset
//   i_enable      in  1              pipeline step enable (low freezes state)
//   i_wb          in  1              register write request
//   i_mem_to_reg  in  1              writeback source select
//   i_halt        in  1              halt instruction retiring this cycle
//   i_mem_result  in  BUS_SIZE       load data
//   i_alu_result  in  BUS_SIZE       ALU result
//   i_addr_wr     in  REG_ADDR_SIZE  destination register
//   i_addr_rs     in  REG_ADDR_SIZE  read port A address
//   i_addr_rt     in  REG_ADDR_SIZE  read port B address
//   i_dbg_addr    in  REG_ADDR_SIZE  debug read address
//   o_bus_a       out BUS_SIZE       register[i_addr_rs]
//   o_bus_b       out BUS_SIZE       register[i_addr_rt]
//   o_dbg_data    out BUS_SIZE       register[i_dbg_addr]
//   o_wb_data     out BUS_SIZE       selected writeback value (combinational)
//   o_halted      out 1              sticky halt-retired flag
//   o_wr_count    out COUNT_SIZE     committed register write count (wraps)
// -----------------------------------------------------------------------------
module wb_register_file
   import wb_register_file_pkg::*;
#(
   parameter int BUS_SIZE      = DEFAULT_WB_IO_BUS_SIZE,
   parameter int REG_ADDR_SIZE = DEFAULT_REG_ADDR_SIZE,
   parameter int COUNT_SIZE    = DEFAULT_WR_COUNT_SIZE
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_enable,
   input  logic                     i_wb,
   input  logic                     i_mem_to_reg,
   input  logic                     i_halt,
   input  logic [BUS_SIZE-1:0]      i_mem_result,
   input  logic [BUS_SIZE-1:0]      i_alu_result,
   input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
   input  logic [REG_ADDR_SIZE-1:0] i_addr_rs,
   input  logic [REG_ADDR_SIZE-1:0] i_addr_rt,
   input  logic [REG_ADDR_SIZE-1:0] i_dbg_addr,
   output logic [BUS_SIZE-1:0]      o_bus_a,
   output logic [BUS_SIZE-1:0]      o_bus_b,
   output logic [BUS_SIZE-1:0]      o_dbg_data,
   output logic [BUS_SIZE-1:0]      o_wb_data,
   output logic                     o_halted,
   output logic [COUNT_SIZE-1:0]    o_wr_count
);

   localparam int NUM_REGS = 2 ** REG_ADDR_SIZE;
   localparam logic [REG_ADDR_SIZE-1:0] ADDR_ZERO = REG_ADDR_SIZE'(REG_ZERO);
   localparam logic [COUNT_SIZE-1:0]    COUNT_ONE = COUNT_SIZE'(1);

   logic [BUS_SIZE-1:0]   regs [NUM_REGS];
   logic [BUS_SIZE-1:0]   wb_data;
   logic                  halted;
   logic [COUNT_SIZE-1:0] wr_count;
   logic                  commit;
   logic                  halt_capture;

   // Writeback source selection
   wb_register_file_wb_mux #(
      .BUS_SIZE (BUS_SIZE)
   ) u_wb_mux (
      .i_mem_to_reg (i_mem_to_reg),
      .i_mem_result (i_mem_result),
      .i_alu_result (i_alu_result),
      .o_wb_data    (wb_data)
   );

   assign o_wb_data = wb_data;

   // The halted flag used here is the pre-edge value, so a write retiring
   // alongside the halt instruction still commits.
   assign commit       = i_enable & i_wb & ~halted & (i_addr_wr != ADDR_ZERO);
   assign halt_capture = i_enable & i_halt & ~halted;

   // Storage, halt flag and commit counter. Entry 0 is cleared on reset but
   // never written afterwards; reads of address 0 are forced to zero anyway.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         halted   <= CLEAR;
         wr_count <= '0;
      end else begin
         if (commit) begin
            regs[i_addr_wr] <= wb_data;
            wr_count        <= wr_count + COUNT_ONE;
         end
         if (halt_capture) begin
            halted <= HIGH;
         end
      end
   end

   assign o_halted   = halted;
   assign o_wr_count = wr_count;

   // Read ports
   always_comb begin
      o_bus_a    = '0;
      o_bus_b    = '0;
      o_dbg_data = '0;

      if (i_addr_rs != ADDR_ZERO) begin
         o_bus_a = regs[i_addr_rs];
      end
      if (i_addr_rt != ADDR_ZERO) begin
         o_bus_b = regs[i_addr_rt];
      end
      if (i_dbg_addr != ADDR_ZERO) begin
         o_dbg_data = regs[i_dbg_addr];
      end

`ifdef REGFILE_BYPASS_EN
      // Write-through: commit already excludes address 0, so a match here
      // implies a nonzero read address.
      if (commit && (i_addr_rs == i_addr_wr)) begin
         o_bus_a = wb_data;
      end
      if (commit && (i_addr_rt == i_addr_wr)) begin
         o_bus_b = wb_data;
      end
`endif
   end

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

   localparam int BUS  = 32;
   localparam int AW   = 5;
   localparam int CW   = 32;
   localparam int CW_S = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic            wb;
   logic            mem_to_reg;
   logic            halt;
   logic [BUS-1:0]  mem_result;
   logic [BUS-1:0]  alu_result;
   logic [AW-1:0]   addr_wr;
   logic [AW-1:0]   addr_rs;
   logic [AW-1:0]   addr_rt;
   logic [AW-1:0]   dbg_addr;

   logic [BUS-1:0]  bus_a, bus_b, dbg_data, wb_data;
   logic            halted;
   logic [CW-1:0]   wr_count;

   logic [BUS-1:0]  s_bus_a, s_bus_b, s_dbg_data, s_wb_data;
   logic            s_halted;
   logic [CW_S-1:0] s_wr_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_register_file #(
      .BUS_SIZE      (BUS),
      .REG_ADDR_SIZE (AW),
      .COUNT_SIZE    (CW)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_enable     (enable),
      .i_wb         (wb),
      .i_mem_to_reg (mem_to_reg),
      .i_halt       (halt),
      .i_mem_result (mem_result),
      .i_alu_result (alu_result),
      .i_addr_wr    (addr_wr),
      .i_addr_rs    (addr_rs),
      .i_addr_rt    (addr_rt),
      .i_dbg_addr   (dbg_addr),
      .o_bus_a      (bus_a),
      .o_bus_b      (bus_b),
      .o_dbg_data   (dbg_data),
      .o_wb_data    (wb_data),
      .o_halted     (halted),
      .o_wr_count   (wr_count)
   );

   // Same stimulus, narrow counter so the wrap can be reached quickly.
   wb_register_file #(
      .BUS_SIZE      (BUS),
      .REG_ADDR_SIZE (AW),
      .COUNT_SIZE    (CW_S)
   ) dut_small (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_enable     (enable),
      .i_wb         (wb),
      .i_mem_to_reg (mem_to_reg),
      .i_halt       (halt),
      .i_mem_result (mem_result),
      .i_alu_result (alu_result),
      .i_addr_wr    (addr_wr),
      .i_addr_rs    (addr_rs),
      .i_addr_rt    (addr_rt),
      .i_dbg_addr   (dbg_addr),
      .o_bus_a      (s_bus_a),
      .o_bus_b      (s_bus_b),
      .o_dbg_data   (s_dbg_data),
      .o_wb_data    (s_wb_data),
      .o_halted     (s_halted),
      .o_wr_count   (s_wr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset      = 1'b0;
      enable     = 1'b1;
      wb         = 1'b0;
      mem_to_reg = 1'b0;
      halt       = 1'b0;
      mem_result = '0;
      alu_result = '0;
      addr_wr    = '0;
   endtask

   task automatic set_read(input logic [AW-1:0] a);
      addr_rs  = a;
      addr_rt  = a;
      dbg_addr = a;
      #1;
   endtask

   task automatic test_reset();
      idle();
      addr_rs = '0; addr_rt = '0; dbg_addr = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         set_read(AW'(i));
         tests++;
         if (bus_a !== 32'h0 || bus_b !== 32'h0 || dbg_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_read addr=%0d a=%h b=%h dbg=%h expected 0", i, bus_a, bus_b, dbg_data);
         end
      end
      tests++;
      if (halted !== 1'b0) begin
         fails++;
         $display("FAIL reset_halted got=%b expected 0", halted);
      end
      tests++;
      if (wr_count !== 32'd0 || s_wr_count !== 4'd0) begin
         fails++;
         $display("FAIL reset_count got=%0d/%0d expected 0", wr_count, s_wr_count);
      end
   endtask

   task automatic test_write();
      idle();
      wb = 1'b1; alu_result = 32'hDEADBEEF; addr_wr = 5'd5;
      tick();
      idle();
      set_read(5'd5);
      tests++;
      if (bus_a !== 32'hDEADBEEF || bus_b !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL write_reg5 a=%h b=%h dbg=%h expected deadbeef", bus_a, bus_b, dbg_data);
      end
      tests++;
      if (wr_count !== 32'd1) begin
         fails++;
         $display("FAIL write_count got=%0d expected 1", wr_count);
      end
   endtask

   task automatic test_zero_and_enable();
      // write to register 0 is dropped
      idle();
      wb = 1'b1; alu_result = 32'h12345678; addr_wr = 5'd0;
      tick();
      idle();
      set_read(5'd0);
      tests++;
      if (bus_a !== 32'h0 || bus_b !== 32'h0 || dbg_data !== 32'h0 || wr_count !== 32'd1) begin
         fails++;
         $display("FAIL zero_write a=%h b=%h dbg=%h cnt=%0d expected 0/0/0/1", bus_a, bus_b, dbg_data, wr_count);
      end
      // enable low: no commit, but writeback select still live
      enable = 1'b0; wb = 1'b1; addr_wr = 5'd7;
      alu_result = 32'h0000_0777; mem_result = 32'hABCD_0007; mem_to_reg = 1'b1;
      #1;
      tests++;
      if (wb_data !== 32'hABCD_0007) begin
         fails++;
         $display("FAIL wb_sel_mem got=%h expected abcd0007", wb_data);
      end
      mem_to_reg = 1'b0;
      #1;
      tests++;
      if (wb_data !== 32'h0000_0777) begin
         fails++;
         $display("FAIL wb_sel_alu got=%h expected 00000777", wb_data);
      end
      tick();
      idle();
      set_read(5'd7);
      tests++;
      if (bus_a !== 32'h0 || dbg_data !== 32'h0 || wr_count !== 32'd1) begin
         fails++;
         $display("FAIL enable_low a=%h dbg=%h cnt=%0d expected 0/0/1", bus_a, dbg_data, wr_count);
      end
   endtask

   task automatic test_same_cycle();
      logic [BUS-1:0] exp_a;
      idle();
      wb = 1'b1; alu_result = 32'h1111_1111; addr_wr = 5'd9;
      tick();
      alu_result = 32'h2222_2222;
      set_read(5'd9);
`ifdef REGFILE_BYPASS_EN
      exp_a = 32'h2222_2222;
`else
      exp_a = 32'h1111_1111;
`endif
      tests++;
      if (bus_a !== exp_a || bus_b !== exp_a) begin
         fails++;
         $display("FAIL same_cycle_read a=%h b=%h expected %h", bus_a, bus_b, exp_a);
      end
      tests++;
      if (dbg_data !== 32'h1111_1111) begin
         fails++;
         $display("FAIL same_cycle_dbg got=%h expected 11111111", dbg_data);
      end
      tick();
      idle();
      #1;
      tests++;
      if (bus_a !== 32'h2222_2222 || dbg_data !== 32'h2222_2222 || wr_count !== 32'd3) begin
         fails++;
         $display("FAIL same_cycle_after a=%h dbg=%h cnt=%0d expected 22222222/22222222/3", bus_a, dbg_data, wr_count);
      end
   endtask

   task automatic test_wrap();
      idle();
      wb = 1'b1; addr_wr = 5'd10;
      for (int i = 0; i < 12; i++) begin
         alu_result = 32'h100 + 32'(i);
         tick();
      end
      idle();
      #1;
      tests++;
      if (s_wr_count !== 4'hF || wr_count !== 32'd15) begin
         fails++;
         $display("FAIL wrap_pre small=%0d wide=%0d expected 15/15", s_wr_count, wr_count);
      end
      wb = 1'b1; addr_wr = 5'd10; alu_result = 32'h0000_0BAD;
      tick();
      idle();
      set_read(5'd10);
      tests++;
      if (s_wr_count !== 4'h0 || wr_count !== 32'd16) begin
         fails++;
         $display("FAIL wrap_post small=%0d wide=%0d expected 0/16", s_wr_count, wr_count);
      end
      tests++;
      if (bus_a !== 32'h0000_0BAD) begin
         fails++;
         $display("FAIL wrap_data got=%h expected 00000bad", bus_a);
      end
   endtask

   task automatic test_halt();
      idle();
      wb = 1'b1; halt = 1'b1; mem_to_reg = 1'b1;
      mem_result = 32'hCAFE0001; alu_result = 32'h5555_5555; addr_wr = 5'd3;
      tick();
      idle();
      set_read(5'd3);
      tests++;
      if (bus_a !== 32'hCAFE0001 || halted !== 1'b1 || wr_count !== 32'd17) begin
         fails++;
         $display("FAIL halt_commit r3=%h halted=%b cnt=%0d expected cafe0001/1/17", bus_a, halted, wr_count);
      end
      wb = 1'b1; alu_result = 32'hAAAA_AAAA; addr_wr = 5'd4; halt = 1'b1;
      tick();
      idle();
      set_read(5'd4);
      tests++;
      if (bus_a !== 32'h0 || dbg_data !== 32'h0 || wr_count !== 32'd17 || halted !== 1'b1) begin
         fails++;
         $display("FAIL halt_block r4=%h dbg=%h cnt=%0d halted=%b expected 0/0/17/1", bus_a, dbg_data, wr_count, halted);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      reset = 1'b1; wb = 1'b1; halt = 1'b1; alu_result = 32'h7777_7777; addr_wr = 5'd12;
      tick();
      idle();
      tests++;
      if (halted !== 1'b0 || wr_count !== 32'd0 || s_wr_count !== 4'd0) begin
         fails++;
         $display("FAIL reset_mid_ctrl halted=%b cnt=%0d/%0d expected 0/0/0", halted, wr_count, s_wr_count);
      end
      for (int k = 0; k < 5; k++) begin
         logic [AW-1:0] ra;
         case (k)
            0: ra = 5'd3;
            1: ra = 5'd5;
            2: ra = 5'd9;
            3: ra = 5'd10;
            default: ra = 5'd12;
         endcase
         set_read(ra);
         tests++;
         if (bus_a !== 32'h0 || bus_b !== 32'h0 || dbg_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid_reg addr=%0d a=%h b=%h dbg=%h expected 0", ra, bus_a, bus_b, dbg_data);
         end
      end
      // normal operation resumes after reset
      wb = 1'b1; alu_result = 32'h0F0F_0F0F; addr_wr = 5'd31;
      tick();
      idle();
      set_read(5'd31);
      tests++;
      if (bus_b !== 32'h0F0F_0F0F || wr_count !== 32'd1) begin
         fails++;
         $display("FAIL post_reset_write b=%h cnt=%0d expected 0f0f0f0f/1", bus_b, wr_count);
      end
   endtask

   initial begin
      idle();
      addr_rs = '0; addr_rt = '0; dbg_addr = '0;
      test_reset();
      test_write();
      test_zero_and_enable();
      test_same_cycle();
      test_wrap();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
